memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 22 ++
 rtl/memory_stage_dff.sv | 16 +
 rtl/memory_stage_mem_req_fsm.sv | 62 ++++++
 rtl/memory_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared pipeline constants, FSM state encoding and writeback register layout.
package memory_stage_pkg;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} memState_t;

    localparam int DEF_MEM_DONE_MAX = 64;

    typedef struct packed {
        logic [15:0] memData;
        logic [15:0] aluOut;
        logic [15:0] setVal;
        logic [15:0] nextPc;
        logic [15:0] jumpPc;
        logic [15:0] instr;
        logic        regWrt;
        logic        halt;
        logic        err;
        logic [2:0]  regWrtSrc;
        logic [2:0]  writeReg;
    } wbRegs_t;

endpackage

// File: rtl/memory_stage_dff.sv
// dff: width-parameterised register cell with asynchronous active-low reset.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= d;
    end

endmodule

// File: rtl/memory_stage_mem_req_fsm.sv
// mem_req_fsm: data-memory request FSM with captured request fields and saturating WAIT timeout counter.
module mem_req_fsm
    import memory_stage_pkg::*;
#(
    parameter int MEM_DONE_MAX = DEF_MEM_DONE_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memEn,
    input  logic        memWrt,
    input  logic [15:0] aluOut,
    input  logic [15:0] reg2Data,
    input  logic        memDone,
    output logic        memReq,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    output logic        stall,
    output logic        done,
    output logic        timeout
);

    localparam int CW = $clog2(MEM_DONE_MAX + 1);

    memState_t   state;
    logic [CW-1:0] waitCnt;
    logic        capWr;
    logic [15:0] capAddr;
    logic [15:0] capWData;
    logic        start;

    // Gated by rst so the request fields read zero while reset is held.
    assign start    = rst && state == IDLE && memEn && !aluOut[0];
    assign done     = state == WAIT && memDone;
    // The timeout cycle releases stall so the faulting instruction can retire.
    assign timeout  = state == WAIT && !memDone && waitCnt >= CW'(MEM_DONE_MAX - 1);
    assign stall    = start || (state == WAIT && !memDone && !timeout);
    assign memReq   = start;
    assign memWr    = state == WAIT ? capWr    : start && memWrt;
    assign memAddr  = state == WAIT ? capAddr  : (start ? aluOut   : 16'h0);
    assign memWData = state == WAIT ? capWData : (start ? reg2Data : 16'h0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            capWr    <= 1'b0;
            capAddr  <= '0;
            capWData <= '0;
        end else if (start) begin
            state    <= WAIT;
            waitCnt  <= '0;
            capWr    <= memWrt;
            capAddr  <= aluOut;
            capWData <= reg2Data;
        end else if (state == WAIT) begin
            state    <= (memDone || timeout) ? IDLE : WAIT;
            waitCnt  <= waitCnt == CW'(MEM_DONE_MAX) ? waitCnt : waitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage issuing data-memory requests, stalling upstream and
// registering results into the writeback pipeline registers.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MEM_DONE_MAX = DEF_MEM_DONE_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluOut,
    input  logic [15:0] reg2Data,
    input  logic        memEn,
    input  logic        memWrt,
    input  logic        regWrt,
    input  logic        halt,
    input  logic        err,
    input  logic        doBranch,
    input  logic [2:0]  regWrtSrc,
    input  logic [2:0]  writeReg,
    input  logic [15:0] nextPc,
    input  logic [15:0] jumpPc,
    input  logic [15:0] setVal,
    input  logic [15:0] instr,
    output logic        memReq,
    output logic        memWr,
    output logic [15:0] memAddr,
    output logic [15:0] memWData,
    input  logic [15:0] memRData,
    input  logic        memDone,
    output logic        stall,
    output logic        pcRedirect,
    output logic [15:0] memDataOut,
    output logic [15:0] aluOutOut,
    output logic [15:0] setValOut,
    output logic [15:0] nextPcOut,
    output logic [15:0] jumpPcOut,
    output logic [15:0] instrOut,
    output logic        regWrtOut,
    output logic        haltOut,
    output logic        errOut,
    output logic [2:0]  regWrtSrcOut,
    output logic [2:0]  writeRegOut
);

    logic    done;
    logic    timeout;
    logic    fault;
    wbRegs_t wbD;
    wbRegs_t wbQ;

    mem_req_fsm #(.MEM_DONE_MAX(MEM_DONE_MAX)) uFsm (
        .clk      (clk),
        .rst      (rst),
        .memEn    (memEn),
        .memWrt   (memWrt),
        .aluOut   (aluOut),
        .reg2Data (reg2Data),
        .memDone  (memDone),
        .memReq   (memReq),
        .memWr    (memWr),
        .memAddr  (memAddr),
        .memWData (memWData),
        .stall    (stall),
        .done     (done),
        .timeout  (timeout)
    );

    // Misaligned accesses and timeouts retire as errors without writing a register.
    assign fault      = (memEn && aluOut[0]) || timeout;
    assign pcRedirect = doBranch && !stall;

    always_comb begin
        wbD        = wbQ;
        wbD.regWrt = 1'b0;
        wbD.halt   = 1'b0;
        wbD.err    = 1'b0;
        if (!stall)
            wbD = '{memData:   done ? memRData : 16'h0,
                    aluOut:    aluOut,
                    setVal:    setVal,
                    nextPc:    nextPc,
                    jumpPc:    jumpPc,
                    instr:     instr,
                    regWrt:    regWrt && !fault,
                    halt:      halt,
                    err:       err || fault,
                    regWrtSrc: regWrtSrc,
                    writeReg:  writeReg};
    end

    dff #(.W($bits(wbRegs_t))) uWb (
        .clk (clk),
        .rst (rst),
        .d   (wbD),
        .q   (wbQ)
    );

    assign memDataOut   = wbQ.memData;
    assign aluOutOut    = wbQ.aluOut;
    assign setValOut    = wbQ.setVal;
    assign nextPcOut    = wbQ.nextPc;
    assign jumpPcOut    = wbQ.jumpPc;
    assign instrOut     = wbQ.instr;
    assign regWrtOut    = wbQ.regWrt;
    assign haltOut      = wbQ.halt;
    assign errOut       = wbQ.err;
    assign regWrtSrcOut = wbQ.regWrtSrc;
    assign writeRegOut  = wbQ.writeReg;

endmodule
